// File: rtl/asym_fifo_pkg.sv
// Shared widths, pointer types and helpers for the 9-bit write / 18-bit read FIFO controller.
package asym_fifo_pkg;

    localparam int unsigned RATIO         = 2;
    localparam int unsigned NARROW_W      = 9;
    localparam int unsigned WIDE_W        = 18;
    localparam int unsigned WR_ADDR_WIDTH = 11;
    localparam int unsigned RD_ADDR_WIDTH = WR_ADDR_WIDTH - 1;
    localparam int unsigned WR_DATA_WIDTH = NARROW_W;
    localparam int unsigned RD_DATA_WIDTH = WIDE_W;
    localparam int unsigned SKID_DEPTH    = 2;

    typedef logic [WR_ADDR_WIDTH:0] ptr_narrow_t;
    typedef logic [RD_ADDR_WIDTH:0] ptr_wide_t;

    // Wide-word pointer expressed in narrow entries (lap bit carries through).
    function automatic ptr_narrow_t wide_to_narrow(input ptr_wide_t p);
        return ptr_narrow_t'(p) * ptr_narrow_t'(RATIO);
    endfunction

endpackage

// File: rtl/asym_fifo_ctrl_9to18_if.sv
// Push stream, pop stream and BRAM port bundle of the asymmetric FIFO controller.
interface asym_fifo_ctrl_9to18_if;
    import asym_fifo_pkg::*;

    logic                     push_valid_i;
    logic [WR_DATA_WIDTH-1:0] push_data_i;
    logic                     push_ready_o;
    logic                     pop_valid_o;
    logic [RD_DATA_WIDTH-1:0] pop_data_o;
    logic                     pop_ready_i;
    logic [WR_ADDR_WIDTH:0]   level_o;
    logic                     WEN_o;
    logic [WR_ADDR_WIDTH-1:0] WR_ADDR_o;
    logic [WR_DATA_WIDTH-1:0] WDATA_o;
    logic                     REN_o;
    logic [RD_ADDR_WIDTH-1:0] RD_ADDR_o;
    logic [RD_DATA_WIDTH-1:0] RDATA_i;

    // Controller side.
    modport slave (
        input  push_valid_i, push_data_i, pop_ready_i, RDATA_i,
        output push_ready_o, pop_valid_o, pop_data_o, level_o,
               WEN_o, WR_ADDR_o, WDATA_o, REN_o, RD_ADDR_o
    );

    // Producer / consumer / BRAM side.
    modport master (
        output push_valid_i, push_data_i, pop_ready_i, RDATA_i,
        input  push_ready_o, pop_valid_o, pop_data_o, level_o,
               WEN_o, WR_ADDR_o, WDATA_o, REN_o, RD_ADDR_o
    );

endinterface

// File: rtl/asym_fifo_skid2.sv
// Two-entry in-order buffer that lands BRAM read data and presents it on a valid/ready stream.
module asym_fifo_skid2 #(
    parameter int unsigned W = 18
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         cap_valid,
    input  logic [W-1:0] cap_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [1:0]   count_q;
    logic [W-1:0] head_q;
    logic [W-1:0] tail_q;
    logic         pop;

    assign pop       = out_ready && (count_q != 2'd0);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign count     = count_q;

    // Head is always entry 0; a pop shifts the tail forward.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case ({cap_valid, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q  <= cap_data;
                        count_q <= 2'd1;
                    end else if (count_q == 2'd1) begin
                        tail_q  <= cap_data;
                        count_q <= 2'd2;
                    end
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= cap_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= cap_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/asym_fifo_ctrl_9to18.sv
// FIFO controller for a 9-bit write / 18-bit read BRAM: pairs byte-stream entries into wide words.
module asym_fifo_ctrl_9to18
    import asym_fifo_pkg::*;
(
    input  logic                    clock0,
    input  logic                    reset,
    input  logic                    flush_i,
    asym_fifo_ctrl_9to18_if.slave   bus
);

    localparam ptr_narrow_t DEPTH = ptr_narrow_t'(2 ** WR_ADDR_WIDTH);

    logic                     clr;
    ptr_narrow_t              wp;
    ptr_wide_t                rp;
    ptr_narrow_t              level;
    ptr_wide_t                avail;
    logic                     inflight;
    logic                     full;
    logic                     push_ready;
    logic                     push_fire;
    logic                     ren;
    logic                     credit_ok;
    logic [1:0]               skid_count;
    logic                     skid_valid;
    logic [RD_DATA_WIDTH-1:0] skid_data;

    assign clr        = reset | flush_i;
    assign level      = wp - wide_to_narrow(rp);
    assign full       = (level == DEPTH);
    assign avail      = level[WR_ADDR_WIDTH:1];
    assign push_ready = !full && !clr;
    assign push_fire  = bus.push_valid_i && push_ready;

    // Only whole committed words are read, and only while the skid can absorb the return.
    assign credit_ok  = (3'(skid_count) + 3'(inflight)) < 3'(SKID_DEPTH);
    assign ren        = !clr && (avail > ptr_wide_t'(inflight)) && credit_ok;

    always_ff @(posedge clock0) begin
        if (clr) begin
            wp       <= '0;
            rp       <= '0;
            inflight <= 1'b0;
        end else begin
            wp       <= wp + ptr_narrow_t'(push_fire);
            rp       <= rp + ptr_wide_t'(ren);
            inflight <= ren;
        end
    end

    // A cleared inflight drops whatever RDATA_i returns after reset/flush.
    asym_fifo_skid2 #(
        .W (RD_DATA_WIDTH)
    ) u_skid (
        .clk       (clock0),
        .clr       (clr),
        .cap_valid (inflight),
        .cap_data  (bus.RDATA_i),
        .out_valid (skid_valid),
        .out_data  (skid_data),
        .out_ready (bus.pop_ready_i),
        .count     (skid_count)
    );

    assign bus.push_ready_o = push_ready;
    assign bus.pop_valid_o  = skid_valid && !clr;
    assign bus.pop_data_o   = clr ? '0 : skid_data;
    assign bus.level_o      = clr ? '0 : level;
    assign bus.WEN_o        = push_fire;
    assign bus.WR_ADDR_o    = clr ? '0 : wp[WR_ADDR_WIDTH-1:0];
    assign bus.WDATA_o      = clr ? '0 : bus.push_data_i;
    assign bus.REN_o        = ren;
    assign bus.RD_ADDR_o    = clr ? '0 : rp[RD_ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_asym_fifo_ctrl_9to18.sv
// Scoreboard bench for asym_fifo_ctrl_9to18 with a behavioural 9w/18r BRAM and byte-pairing model.
module tb_asym_fifo_ctrl_9to18;
    import asym_fifo_pkg::*;

    logic clock0 = 1'b0;
    logic reset;
    logic flush_i;

    int vectors    = 0;
    int miscompares = 0;
    int n_pop      = 0;

    logic [8:0]  bq[$];
    logic [17:0] exp_q[$];
    logic [8:0]  mem [0:2047];

    asym_fifo_ctrl_9to18_if bus();

    asym_fifo_ctrl_9to18 dut (
        .clock0  (clock0),
        .reset   (reset),
        .flush_i (flush_i),
        .bus     (bus)
    );

    always #5 clock0 = ~clock0;

    // BRAM: narrow write, wide read with one cycle latency; even entry in the low lane.
    always @(posedge clock0) begin
        if (bus.WEN_o) mem[bus.WR_ADDR_o] <= bus.WDATA_o;
        if (bus.REN_o) bus.RDATA_i <= {mem[{bus.RD_ADDR_o, 1'b1}], mem[{bus.RD_ADDR_o, 1'b0}]};
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    // Model: every two accepted bytes form one expected word; pops must come out in that order.
    always @(negedge clock0) begin
        if (reset || flush_i) begin
            bq.delete();
            exp_q.delete();
        end else begin
            check("wen", 32'(bus.WEN_o), 32'(bus.push_valid_i && bus.push_ready_o));
            if (bus.push_valid_i && bus.push_ready_o) begin
                check("wdata", 32'(bus.WDATA_o), 32'(bus.push_data_i));
                bq.push_back(bus.push_data_i);
                if (bq.size() == 2) begin
                    exp_q.push_back({bq[1], bq[0]});
                    bq.delete();
                end
            end
            if (bus.pop_valid_o && bus.pop_ready_i) begin
                n_pop++;
                if (exp_q.size() == 0) fail_now("pop_underflow");
                else check("pop_data", 32'(bus.pop_data_o), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clock0);
        #1;
    endtask

    task automatic drain(input int budget, input string name);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            cyc();
            k++;
        end
        if (exp_q.size() != 0) fail_now(name);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_push_ready"}, 32'(bus.push_ready_o), 32'd0);
        check({tag, "_pop_valid"},  32'(bus.pop_valid_o),  32'd0);
        check({tag, "_pop_data"},   32'(bus.pop_data_o),   32'd0);
        check({tag, "_level"},      32'(bus.level_o),      32'd0);
        check({tag, "_wen"},        32'(bus.WEN_o),        32'd0);
        check({tag, "_ren"},        32'(bus.REN_o),        32'd0);
        check({tag, "_wr_addr"},    32'(bus.WR_ADDR_o),    32'd0);
        check({tag, "_rd_addr"},    32'(bus.RD_ADDR_o),    32'd0);
        check({tag, "_wdata"},      32'(bus.WDATA_o),      32'd0);
    endtask

    task automatic random_stream(input int n_bytes, input int budget);
        int pushed = 0;
        int k = 0;
        while (pushed < n_bytes && k < budget) begin
            cyc();
            bus.push_valid_i = 1'($urandom_range(0, 1));
            bus.push_data_i  = 9'($urandom);
            bus.pop_ready_i  = ($urandom_range(0, 3) != 0);
            @(negedge clock0);
            if (bus.push_valid_i && bus.push_ready_o) pushed++;
            k++;
        end
        if (pushed < n_bytes) fail_now("random_stream");
    endtask

    initial begin
        int n;
        int k;
        int pops_before;

        reset            = 1'b1;
        flush_i          = 1'b0;
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = 9'h1FF;
        bus.pop_ready_i  = 1'b1;
        @(negedge clock0);
        check_all_zero("reset");

        // Directed: first pair, latency of write, read issue and pop.
        cyc();
        reset            = 1'b0;
        bus.push_valid_i = 1'b0;
        @(negedge clock0);
        check("ready_after_reset", 32'(bus.push_ready_o), 32'd1);
        cyc();
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = 9'h001;
        @(negedge clock0);
        check("t1_wr_addr0", 32'(bus.WR_ADDR_o), 32'd0);
        cyc();
        bus.push_data_i = 9'h002;
        @(negedge clock0);
        check("t1_wr_addr1", 32'(bus.WR_ADDR_o), 32'd1);
        check("t1_ren_early", 32'(bus.REN_o), 32'd0);
        cyc();
        bus.push_valid_i = 1'b0;
        @(negedge clock0);
        check("t1_ren", 32'(bus.REN_o), 32'd1);
        check("t1_rd_addr", 32'(bus.RD_ADDR_o), 32'd0);
        cyc();
        @(negedge clock0);
        check("t1_pop_valid_early", 32'(bus.pop_valid_o), 32'd0);
        cyc();
        @(negedge clock0);
        check("t1_pop_valid", 32'(bus.pop_valid_o), 32'd1);
        check("t1_pop_data", 32'(bus.pop_data_o), 32'h00401);

        // Directed: a lone entry stays buffered until its partner arrives.
        cyc();
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = 9'h1AA;
        cyc();
        bus.push_valid_i = 1'b0;
        @(negedge clock0);
        check("t2_level1", 32'(bus.level_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clock0);
            check("t2_ren_idle", 32'(bus.REN_o), 32'd0);
        end
        check("t2_pop_idle", 32'(bus.pop_valid_o), 32'd0);
        cyc();
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = 9'h055;
        cyc();
        bus.push_valid_i = 1'b0;
        k = 0;
        @(negedge clock0);
        while (!bus.pop_valid_o && k < 8) begin
            cyc();
            @(negedge clock0);
            k++;
        end
        if (!bus.pop_valid_o) fail_now("t2_pop_wait");
        else check("t2_pop_data", 32'(bus.pop_data_o), 32'h0ABAA);

        // Fill with the consumer stalled: BRAM capacity plus two words held in the skid.
        cyc();
        bus.pop_ready_i  = 1'b0;
        bus.push_valid_i = 1'b1;
        n = 0;
        bus.push_data_i  = 9'(n);
        k = 0;
        while (k < 3000) begin
            @(negedge clock0);
            if (!bus.push_ready_o) break;
            n++;
            cyc();
            bus.push_data_i = 9'(n);
            k++;
        end
        check("t3_accepted", 32'(n), 32'd2052);
        check("t3_level_full", 32'(bus.level_o), 32'd2048);
        check("t3_skid_valid", 32'(bus.pop_valid_o), 32'd1);
        cyc();
        bus.push_valid_i = 1'b0;
        cyc();
        cyc();
        @(negedge clock0);
        check("t3_ren_stalled", 32'(bus.REN_o), 32'd0);
        check("t3_still_full", 32'(bus.push_ready_o), 32'd0);
        pops_before = n_pop;
        cyc();
        bus.pop_ready_i = 1'b1;
        drain(6000, "t3_drain");
        check("t3_pop_count", 32'(n_pop - pops_before), 32'd1026);

        // Random traffic across many pointer laps.
        random_stream(5000, 40000);
        cyc();
        bus.push_valid_i = 1'b0;
        bus.pop_ready_i  = 1'b1;
        drain(3000, "t4_drain");
        @(negedge clock0);
        check("t4_leftover", 32'(bq.size()), 32'd0);
        check("t4_level_empty", 32'(bus.level_o), 32'd0);

        // Flush the cycle after a read issue; the returning word must be dropped.
        cyc();
        bus.pop_ready_i  = 1'b0;
        bus.push_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.push_data_i = 9'(9'h100 + i);
            cyc();
        end
        bus.push_valid_i = 1'b0;
        cyc();
        cyc();
        @(negedge clock0);
        check("t5_level4", 32'(bus.level_o), 32'd4);
        cyc();
        bus.pop_ready_i = 1'b1;
        cyc();
        bus.pop_ready_i = 1'b0;
        k = 0;
        @(negedge clock0);
        while (!bus.REN_o && k < 5) begin
            cyc();
            @(negedge clock0);
            k++;
        end
        if (!bus.REN_o) fail_now("t5_ren_wait");
        cyc();
        flush_i = 1'b1;
        @(negedge clock0);
        check("t5_flush_pop_valid", 32'(bus.pop_valid_o), 32'd0);
        cyc();
        flush_i = 1'b0;
        @(negedge clock0);
        check("t5_pop_valid", 32'(bus.pop_valid_o), 32'd0);
        check("t5_level", 32'(bus.level_o), 32'd0);
        cyc();
        cyc();
        @(negedge clock0);
        check("t5_dropped", 32'(bus.pop_valid_o), 32'd0);
        cyc();
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = 9'h123;
        @(negedge clock0);
        check("t5_wr_addr_restart", 32'(bus.WR_ADDR_o), 32'd0);
        cyc();
        bus.push_data_i = 9'h0F0;
        cyc();
        bus.push_valid_i = 1'b0;
        bus.pop_ready_i  = 1'b1;
        drain(20, "t5_drain");

        // One-cycle reset in the middle of traffic.
        random_stream(60, 400);
        cyc();
        reset            = 1'b1;
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = 9'h1FF;
        bus.pop_ready_i  = 1'b1;
        @(negedge clock0);
        check_all_zero("t6");
        cyc();
        reset            = 1'b0;
        bus.push_valid_i = 1'b0;
        @(negedge clock0);
        check("t6_ready", 32'(bus.push_ready_o), 32'd1);
        check("t6_level", 32'(bus.level_o), 32'd0);
        check("t6_pop_valid", 32'(bus.pop_valid_o), 32'd0);
        cyc();
        bus.push_valid_i = 1'b1;
        bus.push_data_i  = 9'h0C3;
        @(negedge clock0);
        check("t6_wr_addr_restart", 32'(bus.WR_ADDR_o), 32'd0);
        cyc();
        bus.push_data_i = 9'h13C;
        cyc();
        bus.push_valid_i = 1'b0;
        drain(20, "t6_drain");
        cyc();
        @(negedge clock0);
        check("t6_final_empty", 32'(bus.pop_valid_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
